// File: rtl/imm_ext_arbiter.sv
// Round-robin share of one 16->32 immediate extender between decode (req 0) and
// the load/store address unit (req 1), with a single registered output stage.
module imm_ext_arbiter #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32   // must be >= 2*IMM_W for LUI placement
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IMM_W-1:0] req0_imm,
  input  logic [1:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IMM_W-1:0] req1_imm,
  input  logic [1:0]       req1_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_id,
  output logic             bad_mode
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic             last_grant;
  logic             can_accept;
  logic             gnt0, gnt1;
  logic             xfer, xfer_id;
  logic [IMM_W-1:0] sel_imm;
  logic [1:0]       sel_mode;
  logic [OUT_W-1:0] ext;

  assign out_valid = (state == FULL);

  always_comb begin
    can_accept = !out_valid || out_ready;
    // On a tie the requester that did not win last time goes first.
    gnt1       = req1_valid && (!req0_valid || !last_grant);
    gnt0       = req0_valid && !gnt1;
    req0_ready = can_accept && gnt0;
    req1_ready = can_accept && gnt1;
    xfer       = req0_ready || req1_ready;
    xfer_id    = req1_ready;
    sel_imm    = xfer_id ? req1_imm : req0_imm;
    sel_mode   = xfer_id ? req1_mode : req0_mode;
    case (sel_mode)
      2'b01:   ext = {{(OUT_W-IMM_W){1'b0}}, sel_imm};
      2'b10:   ext = {{(OUT_W-IMM_W){1'b0}}, sel_imm} << IMM_W;
      default: ext = {{(OUT_W-IMM_W){sel_imm[IMM_W-1]}}, sel_imm};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_id     <= 1'b0;
      bad_mode   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        EMPTY:   if (xfer) state <= FULL;
        FULL:    if (out_ready && !xfer) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      // xfer only happens when the output slot is free or being drained.
      if (xfer) begin
        out_data   <= ext;
        out_id     <= xfer_id;
        last_grant <= xfer_id;
        if (sel_mode == 2'b11) bad_mode <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter: extension modes, round-robin, stalls, reset.
module tb_imm_ext_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_imm, req1_imm;
  logic [1:0]  req0_mode, req1_mode;
  logic        out_valid, out_ready, out_id, bad_mode;
  logic [31:0] out_data;
  int          checks = 0;
  int          failures = 0;

  imm_ext_arbiter #(.IMM_W(16), .OUT_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_imm(req0_imm), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_imm(req1_imm), .req1_mode(req1_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .bad_mode(bad_mode)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1; idle();
    req0_imm = '0; req1_imm = '0; req0_mode = '0; req1_mode = '0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (out_id !== 1'b0) begin failures++; $display("FAIL reset_id got=%b exp=0", out_id); end
    checks++; if (bad_mode !== 1'b0) begin failures++; $display("FAIL reset_bad got=%b exp=0", bad_mode); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sign_ext();
    req0_valid = 1'b1; req0_imm = 16'h8001; req0_mode = 2'b00;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL sx_r0_ready got=%b exp=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL sx_r1_ready got=%b exp=0", req1_ready); end
    tick(); idle();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sx_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'hFFFF8001) begin failures++; $display("FAIL sx_data got=%h exp=ffff8001", out_data); end
    checks++; if (out_id !== 1'b0) begin failures++; $display("FAIL sx_id got=%b exp=0", out_id); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sx_drain got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'hFFFF8001) begin failures++; $display("FAIL sx_hold got=%h exp=ffff8001", out_data); end
  endtask

  task automatic test_zero_lui();
    req1_valid = 1'b1; req1_imm = 16'h8001; req1_mode = 2'b01;
    #1;
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL zx_r1_ready got=%b exp=1", req1_ready); end
    tick();
    checks++; if (out_data !== 32'h00008001) begin failures++; $display("FAIL zx_data got=%h exp=00008001", out_data); end
    checks++; if (out_id !== 1'b1) begin failures++; $display("FAIL zx_id got=%b exp=1", out_id); end
    req1_imm = 16'h1234; req1_mode = 2'b10;
    tick(); idle();
    checks++; if (out_data !== 32'h12340000) begin failures++; $display("FAIL lui_data got=%h exp=12340000", out_data); end
    checks++; if (out_id !== 1'b1) begin failures++; $display("FAIL lui_id got=%b exp=1", out_id); end
    tick();
  endtask

  task automatic test_round_robin();
    int n0 = 0, n1 = 0;
    logic exp_id;
    logic [31:0] exp_data;
    req0_mode = 2'b01; req1_mode = 2'b01; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_imm = 16'h0A00 + 16'(n0); req1_imm = 16'h0B00 + 16'(n1);
      exp_id = (i % 2 == 1);
      exp_data = exp_id ? {16'h0, 16'h0B00 + 16'(n1)} : {16'h0, 16'h0A00 + 16'(n0)};
      #1;
      checks++; if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL rr_ready i=%0d got=%b%b exp_id=%b", i, req1_ready, req0_ready, exp_id); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_id !== exp_id || out_data !== exp_data) begin
        failures++; $display("FAIL rr_out i=%0d got v=%b id=%b d=%h exp id=%b d=%h", i, out_valid, out_id, out_data, exp_id, exp_data); end
      if (exp_id) n1++; else n0++;
    end
  endtask

  task automatic test_stall();
    // FULL with req1's last result (0x0B02); last grant was req1.
    out_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_imm = 16'h5555; req1_imm = 16'h6666;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++; $display("FAIL stall_ready i=%0d got=%b%b exp=00", i, req1_ready, req0_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h00000B02 || out_id !== 1'b1) begin
        failures++; $display("FAIL stall_hold i=%0d got v=%b d=%h id=%b exp v=1 d=00000b02 id=1", i, out_valid, out_data, out_id); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL stall_release got=%b%b exp=01", req1_ready, req0_ready); end
    tick(); idle();
    checks++; if (out_id !== 1'b0 || out_data !== 32'h00005555) begin
      failures++; $display("FAIL stall_out got id=%b d=%h exp id=0 d=00005555", out_id, out_data); end
    tick();
  endtask

  task automatic test_bad_mode();
    req0_valid = 1'b1; req0_imm = 16'hFFFE; req0_mode = 2'b11;
    tick(); idle();
    checks++; if (out_data !== 32'hFFFFFFFE) begin failures++; $display("FAIL bad_data got=%h exp=fffffffe", out_data); end
    checks++; if (bad_mode !== 1'b1) begin failures++; $display("FAIL bad_set got=%b exp=1", bad_mode); end
    req1_valid = 1'b1; req1_imm = 16'h0001; req1_mode = 2'b00;
    tick(); idle();
    checks++; if (bad_mode !== 1'b1 || out_data !== 32'h00000001) begin
      failures++; $display("FAIL bad_sticky got bad=%b d=%h exp bad=1 d=00000001", bad_mode, out_data); end
    tick();
    checks++; if (bad_mode !== 1'b1) begin failures++; $display("FAIL bad_idle got=%b exp=1", bad_mode); end
  endtask

  task automatic test_async_reset();
    req0_valid = 1'b1; req0_imm = 16'h7FFF; req0_mode = 2'b00; out_ready = 1'b0;
    tick(); idle();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h00007FFF) begin
      failures++; $display("FAIL ar_pre got v=%b d=%h exp v=1 d=00007fff", out_valid, out_data); end
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || bad_mode !== 1'b0 || out_data !== 32'h0) begin
      failures++; $display("FAIL ar_async got v=%b bad=%b d=%h exp 0 0 0", out_valid, bad_mode, out_data); end
    tick();
    reset = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_imm = 16'h0042; req1_imm = 16'h0043;
    req0_mode = 2'b01; req1_mode = 2'b01;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL ar_tie got=%b%b exp=01", req1_ready, req0_ready); end
    tick(); idle();
    checks++; if (out_id !== 1'b0 || out_data !== 32'h00000042) begin
      failures++; $display("FAIL ar_out got id=%b d=%h exp id=0 d=00000042", out_id, out_data); end
  endtask

  initial begin
    test_reset();
    test_sign_ext();
    test_zero_lui();
    test_round_robin();
    test_stall();
    test_bad_mode();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout reached");
    $fatal(1);
  end
endmodule
